// File: rtl/pwm_compare_pkg.sv
// Shared types and helpers for the PWM compare stage: FSM encoding and duty clamping.
package pwm_compare_pkg;

    localparam logic STATE_IDLE    = 1'b0;
    localparam logic STATE_PENDING = 1'b1;

    typedef enum logic {
        IDLE    = STATE_IDLE,
        PENDING = STATE_PENDING
    } state_e;

    // Saturate a requested duty to the longest legal high-time.
    function automatic int unsigned clamp_duty(input int unsigned value, input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_compare_if.sv
// Duty-load valid/ready handshake between the duty source and the PWM compare stage.
interface pwm_compare_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_duty_shadow.sv
// Duty shadow register: accepts a new duty over the handshake and applies it at a period boundary.
module pwm_duty_shadow
    import pwm_compare_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_VALUE  = 200,
    parameter int unsigned DUTY_RESET = 0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             boundary_i,
    pwm_compare_if.slave     duty_if,
    output logic [WIDTH-1:0] duty_active_o
);

    localparam int unsigned      DUTY_MAX = MAX_VALUE + 1;
    localparam logic [WIDTH-1:0] DUTY_RST = WIDTH'(clamp_duty(DUTY_RESET, DUTY_MAX));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             ready_q, ready_d;

    always_ff @(posedge clk) begin
        if (!RST) begin
            state_q  <= IDLE;
            shadow_q <= DUTY_RST;
            active_q <= DUTY_RST;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    // A duty taken on a boundary cycle waits for the following boundary; there is no bypass.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                if (duty_if.duty_valid && ready_q) begin
                    shadow_d = WIDTH'(clamp_duty(32'(duty_if.duty_in), DUTY_MAX));
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (boundary_i) begin
                    active_d = shadow_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    assign duty_if.duty_ready = ready_q;
    assign duty_active_o      = active_q;

endmodule

// File: rtl/pwm_compare.sv
// PWM compare stage: registered PWM and period-done pulse from an upstream wrapping count.
// Optional output inversion, latched per period, when PWM_COMPARE_POLARITY_EN is defined.
module pwm_compare
    import pwm_compare_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MAX_VALUE  = 200,
    parameter int unsigned DUTY_RESET = 0
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] counter,
    pwm_compare_if.slave     duty_if,
`ifdef PWM_COMPARE_POLARITY_EN
    input  logic             pol_inv,
`endif
    output logic [WIDTH-1:0] duty_active,
    output logic             pwm_out,
    output logic             period_done
);

    if (MAX_VALUE + 1 > (2 ** WIDTH) - 1) begin : g_bad_max_value
        $error("pwm_compare: MAX_VALUE+1 does not fit the counter WIDTH");
    end

    logic boundary_c;
    logic in_range_c;
    logic cmp_c;
    logic pwm_q, pwm_d;
    logic period_done_q;

    assign boundary_c = (counter == WIDTH'(MAX_VALUE));
    assign in_range_c = (counter <= WIDTH'(MAX_VALUE));
    assign cmp_c      = (counter < duty_active);

    pwm_duty_shadow #(
        .WIDTH      (WIDTH),
        .MAX_VALUE  (MAX_VALUE),
        .DUTY_RESET (DUTY_RESET)
    ) u_shadow (
        .clk           (clk),
        .RST           (RST),
        .boundary_i    (boundary_c),
        .duty_if       (duty_if),
        .duty_active_o (duty_active)
    );

`ifdef PWM_COMPARE_POLARITY_EN
    logic pol_q, pol_d;

    // Polarity changes only at a period boundary, like the duty.
    always_comb begin
        pol_d = boundary_c ? pol_inv : pol_q;
        pwm_d = in_range_c ? (cmp_c ^ pol_q) : pol_q;
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            pol_q <= 1'b0;
        end else begin
            pol_q <= pol_d;
        end
    end
`else
    always_comb begin
        pwm_d = in_range_c & cmp_c;
    end
`endif

    always_ff @(posedge clk) begin
        if (!RST) begin
            pwm_q         <= 1'b0;
            period_done_q <= 1'b0;
        end else begin
            pwm_q         <= pwm_d;
            period_done_q <= boundary_c;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_done = period_done_q;

endmodule
